dcache_tag_nway: RTL and testbench

Parametrised N-way set-associative tag/state controller for the NPC data cache. It holds valid/dirty/tag per line and tree pseudo-LRU per set. It resolves hit/miss one cycle after a request is accepted, and sequences dirty-victim write-back and line refill through two valid/ready handshakes. It also supports a whole-cache invalidate sweep. It sits between the MEM stage's request/stall logic and the data array / AXI bridge.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_tag_nway_plru.sv | 33 +++
 rtl/dcache_tag_nway.sv | 209 ++++++++++++++++++++
 tb/tb_dcache_tag_nway.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the N-way data-cache tag/state controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        INV
    } dcache_state_t;

    // Tags are stored zero-extended to this width so the line type stays parameter-free.
    localparam int LINE_TAG_W = 64;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [LINE_TAG_W-1:0] tag;
    } dcache_line_t;

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int offset_w);
        return addr_w - $clog2(sets) - offset_w;
    endfunction

endpackage

// File: rtl/dcache_tag_nway_plru.sv
// Tree pseudo-LRU: victim walk over WAYS-1 node bits and the update for an accessed way.
module plru_tree #(
    parameter  int WAYS  = 2,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree_bits,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim,
    output logic [WAYS-2:0]  tree_next
);

    // Node bit 0 means the victim lies in the left subtree; children of n are 2n+1 and 2n+2.
    always_comb begin
        logic [WAY_W-1:0] node;
        node   = '0;
        victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim[WAY_W-1-l] = tree_bits[node];
            node = WAY_W'(2 * int'(node) + 1 + int'(tree_bits[node]));
        end
    end

    always_comb begin
        logic [WAY_W-1:0] node;
        node      = '0;
        tree_next = tree_bits;
        for (int l = 0; l < WAY_W; l++) begin
            tree_next[node] = ~access_way[WAY_W-1-l];
            node = WAY_W'(2 * int'(node) + 1 + int'(access_way[WAY_W-1-l]));
        end
    end

endmodule

// File: rtl/dcache_tag_nway.sv
// N-way set-associative tag/state controller: lookup, dirty write-back, refill and invalidate sweep.
module dcache_tag_nway
    import dcache_pkg::*;
#(
    parameter  int ADDR_W   = 64,
    parameter  int SETS     = 64,
    parameter  int WAYS     = 2,
    parameter  int OFFSET_W = 3,
    localparam int INDEX_W  = index_width(SETS),
    localparam int WAY_W    = $clog2(WAYS),
    localparam int TAG_W    = tag_width(ADDR_W, SETS, OFFSET_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic              req_cacheable,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_uncached,
    output logic [WAY_W-1:0]  resp_way,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WAY_W-1:0]  wb_way,
    output logic              refill_valid,
    input  logic              refill_ready,
    output logic [ADDR_W-1:0] refill_addr,
    output logic [WAY_W-1:0]  refill_way,
    input  logic              inv_all,
    output logic              inv_busy
);

    dcache_state_t      state_q, state_d;
    logic               lookup_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic               req_we_q;
    logic               req_cacheable_q;
    logic [WAY_W-1:0]   victim_way_q;
    logic [TAG_W-1:0]   victim_tag_q;
    logic [INDEX_W-1:0] inv_set_q;

    dcache_line_t       lines_q [SETS][WAYS];
    logic [WAYS-2:0]    plru_q  [SETS];

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    dcache_line_t       set_lines [WAYS];
    logic [WAYS-1:0]    hit_vec;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_found;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   plru_victim;
    logic [WAY_W-1:0]   victim_way;
    logic [WAY_W-1:0]   plru_access;
    logic [WAYS-2:0]    plru_next;
    logic               lookup_hit;
    logic               lookup_miss;
    logic               accept;
    logic               inv_start;
    logic               unused_offset;

    assign req_index     = req_addr_q[OFFSET_W +: INDEX_W];
    assign req_tag       = req_addr_q[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^req_addr_q[OFFSET_W-1:0];

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_lines[w] = lines_q[req_index][w];
            hit_vec[w]   = set_lines[w].valid && (set_lines[w].tag == LINE_TAG_W'(req_tag));
        end
    end

    // Descending scans so the lowest-numbered matching way wins.
    always_comb begin
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!set_lines[w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way  = inv_found ? inv_way : plru_victim;
    assign plru_access = (state_q == REFILL) ? victim_way_q : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree_bits  (plru_q[req_index]),
        .access_way (plru_access),
        .victim     (plru_victim),
        .tree_next  (plru_next)
    );

    assign lookup_hit  = lookup_q & req_cacheable_q & (|hit_vec);
    assign lookup_miss = lookup_q & req_cacheable_q & ~(|hit_vec);

    // A miss drops ready in the same cycle it is detected, before the state register moves.
    assign req_ready = (state_q == IDLE) & ~inv_all & ~lookup_miss;
    assign accept    = req_valid & req_ready;
    assign inv_start = (state_q == IDLE) & inv_all & ~lookup_miss;

    assign resp_valid    = lookup_q;
    assign resp_hit      = lookup_hit;
    assign resp_uncached = lookup_q & ~req_cacheable_q;
    assign resp_way      = lookup_hit ? hit_way : '0;

    assign wb_valid     = (state_q == WB);
    assign wb_addr      = {victim_tag_q, req_index, {OFFSET_W{1'b0}}};
    assign wb_way       = victim_way_q;
    assign refill_valid = (state_q == REFILL);
    assign refill_addr  = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign refill_way   = victim_way_q;
    assign inv_busy     = (state_q == INV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lookup_miss) begin
                    state_d = (set_lines[victim_way].valid && set_lines[victim_way].dirty) ? WB : REFILL;
                end else if (inv_all) begin
                    state_d = INV;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (refill_ready) begin
                    state_d = IDLE;
                end
            end
            INV: begin
                if (inv_set_q == INDEX_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_q        <= 1'b0;
            req_addr_q      <= '0;
            req_we_q        <= 1'b0;
            req_cacheable_q <= 1'b0;
            victim_way_q    <= '0;
            victim_tag_q    <= '0;
            inv_set_q       <= '0;
            lines_q         <= '{default: '0};
            plru_q          <= '{default: '0};
        end else begin
            lookup_q <= accept;
            if (accept) begin
                req_addr_q      <= req_addr;
                req_we_q        <= req_we;
                req_cacheable_q <= req_cacheable;
            end
            if (lookup_miss) begin
                victim_way_q <= victim_way;
                victim_tag_q <= TAG_W'(set_lines[victim_way].tag);
            end
            if (inv_start) begin
                inv_set_q <= '0;
            end else if (state_q == INV) begin
                inv_set_q <= inv_set_q + 1'b1;
            end
            if (lookup_hit) begin
                plru_q[req_index] <= plru_next;
                if (req_we_q) begin
                    lines_q[req_index][hit_way].dirty <= 1'b1;
                end
            end
            if ((state_q == REFILL) && refill_ready) begin
                lines_q[req_index][victim_way_q] <= '{valid: 1'b1, dirty: req_we_q, tag: LINE_TAG_W'(req_tag)};
                plru_q[req_index]                <= plru_next;
            end
            // Sweep discards dirty lines; tags are left as they are since valid gates every use.
            if (state_q == INV) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines_q[inv_set_q][w].valid <= 1'b0;
                    lines_q[inv_set_q][w].dirty <= 1'b0;
                end
                plru_q[inv_set_q] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_tag_nway.sv
// Directed self-checking bench for dcache_tag_nway (4-way, 64 sets, 64-bit addresses).
module tb_dcache_tag_nway;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic        req_cacheable = 1'b0;
    logic        resp_valid, resp_hit, resp_uncached;
    logic [1:0]  resp_way;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [63:0] wb_addr;
    logic [1:0]  wb_way;
    logic        refill_valid;
    logic        refill_ready = 1'b0;
    logic [63:0] refill_addr;
    logic [1:0]  refill_way;
    logic        inv_all = 1'b0;
    logic        inv_busy;

    int tests = 0;
    int failures = 0;

    localparam logic [63:0] ADDR_A = 64'h8000_0040;
    localparam logic [63:0] SET1   = 64'h2000_0008;
    localparam logic [63:0] TAG_STEP = 64'h1_0000;

    dcache_tag_nway #(.ADDR_W(64), .SETS(64), .WAYS(4), .OFFSET_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_cacheable(req_cacheable),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_uncached(resp_uncached), .resp_way(resp_way),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_way(wb_way),
        .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_addr(refill_addr), .refill_way(refill_way),
        .inv_all(inv_all), .inv_busy(inv_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns in the cycle after acceptance.
    task automatic applyStimulus(input logic [63:0] addr, input logic we, input logic cacheable);
        checkOutput("req_ready_before_req", req_ready, 1'b1);
        req_addr      = addr;
        req_we        = we;
        req_cacheable = cacheable;
        req_valid     = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic serviceMiss(output logic [1:0] fill_way);
        bit done;
        done     = 1'b0;
        fill_way = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (refill_valid) begin
                fill_way     = refill_way;
                refill_ready = 1'b1;
                tick();
                refill_ready = 1'b0;
                done         = 1'b1;
            end else begin
                wb_ready = wb_valid;
                tick();
                wb_ready = 1'b0;
            end
        end
        checkOutput("miss_serviced", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] way;
        int busy_cycles;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", req_ready, 1'b1);
        checkOutput("rst_resp_valid", resp_valid, 1'b0);
        checkOutput("rst_wb_valid", wb_valid, 1'b0);
        checkOutput("rst_refill_valid", refill_valid, 1'b0);
        checkOutput("rst_inv_busy", inv_busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Cold load miss, refill, replay hit.
        applyStimulus(ADDR_A, 1'b0, 1'b1);
        checkOutput("t1_resp_valid", resp_valid, 1'b1);
        checkOutput("t1_resp_hit", resp_hit, 1'b0);
        checkOutput("t1_ready_low_on_miss", req_ready, 1'b0);
        tick();
        checkOutput("t1_refill_valid", refill_valid, 1'b1);
        checkOutput("t1_wb_valid", wb_valid, 1'b0);
        checkOutput("t1_refill_addr", refill_addr, ADDR_A);
        checkOutput("t1_refill_way", refill_way, 2'd0);
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
        checkOutput("t1_ready_after_refill", req_ready, 1'b1);
        checkOutput("t1_refill_dropped", refill_valid, 1'b0);
        applyStimulus(ADDR_A, 1'b0, 1'b1);
        checkOutput("t1_replay_hit", resp_hit, 1'b1);
        checkOutput("t1_replay_way", resp_way, 2'd0);

        // Store hit, fill the rest of set 8, then evict the dirty line.
        applyStimulus(ADDR_A, 1'b1, 1'b1);
        checkOutput("t3_store_hit", resp_hit, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(ADDR_A + TAG_STEP * k, 1'b0, 1'b1);
            checkOutput("t3_fill_miss", resp_hit, 1'b0);
            serviceMiss(way);
            checkOutput("t3_fill_way", way, 64'(k));
        end
        applyStimulus(ADDR_A + TAG_STEP * 4, 1'b0, 1'b1);
        checkOutput("t3_evict_miss", resp_hit, 1'b0);
        tick();
        checkOutput("t3_wb_valid", wb_valid, 1'b1);
        checkOutput("t3_wb_addr", wb_addr, ADDR_A);
        checkOutput("t3_wb_way", wb_way, 2'd0);
        checkOutput("t3_no_refill_yet", refill_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t3_wb_hold_valid", wb_valid, 1'b1);
            checkOutput("t3_wb_hold_addr", wb_addr, ADDR_A);
            checkOutput("t3_wb_hold_no_refill", refill_valid, 1'b0);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checkOutput("t3_wb_done", wb_valid, 1'b0);
        checkOutput("t3_refill_after_wb", refill_valid, 1'b1);
        checkOutput("t3_refill_addr", refill_addr, ADDR_A + TAG_STEP * 4);
        checkOutput("t3_refill_way", refill_way, 2'd0);
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
        checkOutput("t3_ready_after_refill", req_ready, 1'b1);

        // PLRU eviction in set 1: fill 0..3, touch 0,2,1,3, fifth tag must go to way 0.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(SET1 + TAG_STEP * k, 1'b0, 1'b1);
            serviceMiss(way);
            checkOutput("t2_fill_way", way, 64'(k));
        end
        begin
            int order [4] = '{0, 2, 1, 3};
            for (int i = 0; i < 4; i++) begin
                applyStimulus(SET1 + TAG_STEP * order[i], 1'b0, 1'b1);
                checkOutput("t2_touch_hit", resp_hit, 1'b1);
                checkOutput("t2_touch_way", resp_way, 64'(order[i]));
            end
        end
        applyStimulus(SET1 + TAG_STEP * 4, 1'b0, 1'b1);
        checkOutput("t2_fifth_miss", resp_hit, 1'b0);
        serviceMiss(way);
        checkOutput("t2_plru_victim", way, 2'd0);

        // Uncacheable access.
        applyStimulus(64'h1000_0000, 1'b0, 1'b0);
        checkOutput("t4_resp_valid", resp_valid, 1'b1);
        checkOutput("t4_uncached", resp_uncached, 1'b1);
        checkOutput("t4_hit", resp_hit, 1'b0);
        checkOutput("t4_ready", req_ready, 1'b1);
        tick();
        checkOutput("t4_no_refill", refill_valid, 1'b0);
        checkOutput("t4_no_wb", wb_valid, 1'b0);

        // Invalidate sweep beats a simultaneous request.
        applyStimulus(ADDR_A + TAG_STEP * 4, 1'b0, 1'b1);
        checkOutput("t5_pre_hit", resp_hit, 1'b1);
        req_addr      = ADDR_A + TAG_STEP * 4;
        req_cacheable = 1'b1;
        req_valid     = 1'b1;
        inv_all       = 1'b1;
        #1;
        checkOutput("t5_ready_low_with_inv", req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        inv_all   = 1'b0;
        checkOutput("t5_req_not_accepted", resp_valid, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 100 && inv_busy; i++) begin
            busy_cycles++;
            if (req_ready) checkOutput("t5_ready_during_inv", req_ready, 1'b0);
            tick();
        end
        checkOutput("t5_inv_cycles", busy_cycles, 64);
        checkOutput("t5_ready_after_inv", req_ready, 1'b1);
        applyStimulus(ADDR_A + TAG_STEP * 4, 1'b0, 1'b1);
        checkOutput("t5_miss_after_inv", resp_hit, 1'b0);

        // Reset in the middle of the refill handshake.
        tick();
        checkOutput("t6_in_refill", refill_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_refill_drops_async", refill_valid, 1'b0);
        checkOutput("t6_ready_in_reset", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("t6_ready_after_reset", req_ready, 1'b1);
        applyStimulus(ADDR_A + TAG_STEP * 4, 1'b0, 1'b1);
        checkOutput("t6_miss_a", resp_hit, 1'b0);
        serviceMiss(way);
        applyStimulus(SET1 + TAG_STEP * 4, 1'b0, 1'b1);
        checkOutput("t6_miss_b", resp_hit, 1'b0);
        serviceMiss(way);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
